vga_frame_sequencer: RTL and testbench

//  Frame-synchronous controller for the VGA pattern datapath. It detects frame boundaries on vsync and

---
 rtl/vga_frame_sequencer.sv | 142 ++++++++++++++
 tb/tb_vga_frame_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_sequencer.sv
// Frame-synchronous phase/mode sequencer for the VGA pattern datapath.
// Define SEQ_AUTOCYCLE_EN to enable dwell-based automatic mode cycling.
module vga_frame_sequencer #(
    parameter int PHASE_W      = 10,
    parameter int NUM_MODES    = 4,
    parameter int MODE_W       = 2,
    parameter int DWELL_FRAMES = 120,
    parameter int VSYNC_POL    = 0
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_vsync,
    input  logic               i_btn_pause,
    input  logic               i_btn_step,
    input  logic               i_btn_mode,
    input  logic [1:0]         i_speed,
    output logic [PHASE_W-1:0] o_phase,
    output logic [MODE_W-1:0]  o_mode,
    output logic               o_frame_tick,
    output logic               o_paused
);

    typedef enum logic {
        RUN    = 1'b0,
        PAUSED = 1'b1
    } state_t;

    localparam logic VSYNC_ACTIVE = (VSYNC_POL != 0);

    // Button vectors are ordered {mode, step, pause}
    logic               r_vsyncQ;
    logic               r_tick;
    logic [2:0]         r_btnMeta;
    logic [2:0]         r_btnSync;
    logic [2:0]         r_btnPrev;
    logic [2:0]         r_pend;
    state_t             r_state;
    state_t             w_nextState;
    logic [PHASE_W-1:0] r_phase;
    logic [MODE_W-1:0]  r_mode;
    logic               w_vsyncEdge;
    logic [2:0]         w_btnRise;
    logic               w_advance;
    logic               w_modeAdvance;
    logic [PHASE_W-1:0] w_stepSize;

    assign w_vsyncEdge = (i_vsync == VSYNC_ACTIVE) && (r_vsyncQ != VSYNC_ACTIVE);
    assign w_btnRise   = r_btnSync & ~r_btnPrev;
    assign w_stepSize  = PHASE_W'(1) << i_speed;

    // vsync_q starts at the active level so a vsync already active at release is not an edge
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vsyncQ <= VSYNC_ACTIVE;
            r_tick   <= 1'b0;
        end else begin
            r_vsyncQ <= i_vsync;
            r_tick   <= w_vsyncEdge;
        end
    end

    // A new edge in the tick cycle survives the clear, so it is served by the next frame
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_btnMeta <= '0;
            r_btnSync <= '0;
            r_btnPrev <= '0;
            r_pend    <= '0;
        end else begin
            r_btnMeta <= {i_btn_mode, i_btn_step, i_btn_pause};
            r_btnSync <= r_btnMeta;
            r_btnPrev <= r_btnSync;
            r_pend    <= (r_tick ? 3'b000 : r_pend) | w_btnRise;
        end
    end

    always_comb begin
        w_nextState = r_state;
        if (r_tick && r_pend[0]) begin
            w_nextState = (r_state == RUN) ? PAUSED : RUN;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_nextState;
        end
    end

    // A step request while running is absorbed into the normal advance
    assign w_advance = r_tick && ((w_nextState == RUN) || r_pend[1]);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_phase <= '0;
        end else if (w_advance) begin
            r_phase <= r_phase + w_stepSize;
        end
    end

`ifdef SEQ_AUTOCYCLE_EN
    localparam int DWELL_W = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;

    logic [DWELL_W-1:0] r_dwell;
    logic               w_dwellExpire;

    assign w_dwellExpire = r_tick && (w_nextState == RUN) &&
                           (r_dwell == DWELL_W'(DWELL_FRAMES - 1));
    assign w_modeAdvance = r_tick && (r_pend[2] || w_dwellExpire);

    // Manual mode changes restart the dwell; the count freezes while paused
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dwell <= '0;
        end else if (r_tick) begin
            if (r_pend[2] || w_dwellExpire) begin
                r_dwell <= '0;
            end else if (w_nextState == RUN) begin
                r_dwell <= r_dwell + DWELL_W'(1);
            end
        end
    end
`else
    assign w_modeAdvance = r_tick && r_pend[2];
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mode <= '0;
        end else if (w_modeAdvance) begin
            r_mode <= (r_mode == MODE_W'(NUM_MODES - 1)) ? '0 : r_mode + MODE_W'(1);
        end
    end

    assign o_phase      = r_phase;
    assign o_mode       = r_mode;
    assign o_frame_tick = r_tick;
    assign o_paused     = (r_state == PAUSED);

endmodule

// File: tb/tb_vga_frame_sequencer.sv
// Directed testbench for vga_frame_sequencer (active-low vsync, DWELL_FRAMES=3).
// Build with SEQ_AUTOCYCLE_EN defined to exercise the auto-cycling sequence instead.
module tb_vga_frame_sequencer;

    logic       clk;
    logic       rstN;
    logic       vsync;
    logic       btnPause;
    logic       btnStep;
    logic       btnMode;
    logic [1:0] speed;
    logic [9:0] phase;
    logic [1:0] mode;
    logic       frameTick;
    logic       paused;

    int errors = 0;
    int checks = 0;
    int ticks;

    vga_frame_sequencer #(
        .PHASE_W      (10),
        .NUM_MODES    (4),
        .MODE_W       (2),
        .DWELL_FRAMES (3),
        .VSYNC_POL    (0)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rstN),
        .i_vsync      (vsync),
        .i_btn_pause  (btnPause),
        .i_btn_step   (btnStep),
        .i_btn_mode   (btnMode),
        .i_speed      (speed),
        .o_phase      (phase),
        .o_mode       (mode),
        .o_frame_tick (frameTick),
        .o_paused     (paused)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // One short frame: vsync active for 2 cycles then idle for 4; counts tick cycles seen
    task automatic doFrame(output int tickCount);
        tickCount = 0;
        vsync = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (frameTick) tickCount++;
        end
        vsync = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (frameTick) tickCount++;
        end
    endtask

    // Pulse a button (0 pause, 1 step, 2 mode) long enough to pass the synchronizer
    task automatic applyStimulus(input int btnSel);
        case (btnSel)
            0:       btnPause = 1'b1;
            1:       btnStep  = 1'b1;
            default: btnMode  = 1'b1;
        endcase
        repeat (2) @(negedge clk);
        btnPause = 1'b0;
        btnStep  = 1'b0;
        btnMode  = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        rstN     = 1'b0;
        vsync    = 1'b0;
        btnPause = 1'b0;
        btnStep  = 1'b0;
        btnMode  = 1'b0;
        speed    = 2'd0;
        repeat (3) @(negedge clk);
        $display("[TB] reset with vsync held active");
        checkOutput("rst_phase", 32'(phase), 32'd0);
        checkOutput("rst_mode", 32'(mode), 32'd0);
        checkOutput("rst_paused", 32'(paused), 32'd0);
        checkOutput("rst_tick", 32'(frameTick), 32'd0);

        rstN  = 1'b1;
        ticks = 0;
        repeat (6) begin
            @(negedge clk);
            if (frameTick) ticks++;
        end
        vsync = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (frameTick) ticks++;
        end
        checkOutput("release_no_tick", 32'(ticks), 32'd0);
        checkOutput("release_phase", 32'(phase), 32'd0);

`ifdef SEQ_AUTOCYCLE_EN
        $display("[TB] auto-cycle with dwell of 3 frames");
        doFrame(ticks);
        doFrame(ticks);
        checkOutput("auto_t2_mode", 32'(mode), 32'd0);
        doFrame(ticks);
        checkOutput("auto_t3_mode", 32'(mode), 32'd1);
        doFrame(ticks);
        doFrame(ticks);
        checkOutput("auto_t5_mode", 32'(mode), 32'd1);
        doFrame(ticks);
        checkOutput("auto_t6_mode", 32'(mode), 32'd2);
        applyStimulus(0);
        doFrame(ticks);
        doFrame(ticks);
        doFrame(ticks);
        checkOutput("auto_paused", 32'(paused), 32'd1);
        checkOutput("auto_paused_mode", 32'(mode), 32'd2);
        applyStimulus(0);
        doFrame(ticks);
        doFrame(ticks);
        checkOutput("auto_resume_t2_mode", 32'(mode), 32'd2);
        doFrame(ticks);
        checkOutput("auto_resume_t3_mode", 32'(mode), 32'd3);
        doFrame(ticks);
        doFrame(ticks);
        applyStimulus(2);
        doFrame(ticks);
        checkOutput("auto_manual_and_expiry", 32'(mode), 32'd0);
        doFrame(ticks);
        doFrame(ticks);
        checkOutput("auto_after_clear_t2", 32'(mode), 32'd0);
        doFrame(ticks);
        checkOutput("auto_after_clear_t3", 32'(mode), 32'd1);
`else
        $display("[TB] phase accumulation");
        speed = 2'd2;
        doFrame(ticks);
        checkOutput("tick_one_cycle", 32'(ticks), 32'd1);
        checkOutput("phase_f1", 32'(phase), 32'd4);
        repeat (4) doFrame(ticks);
        checkOutput("phase_f5", 32'(phase), 32'd20);
        speed = 2'd3;
        for (int i = 0; i < 125; i++) doFrame(ticks);
        checkOutput("phase_1020", 32'(phase), 32'd1020);
        checkOutput("mode_no_autocycle", 32'(mode), 32'd0);
        doFrame(ticks);
        checkOutput("phase_wrap", 32'(phase), 32'd4);

        $display("[TB] pause and single step");
        speed = 2'd1;
        applyStimulus(0);
        doFrame(ticks);
        checkOutput("pause_enter", 32'(paused), 32'd1);
        checkOutput("pause_enter_phase", 32'(phase), 32'd4);
        doFrame(ticks);
        doFrame(ticks);
        checkOutput("pause_frozen", 32'(phase), 32'd4);
        applyStimulus(1);
        doFrame(ticks);
        checkOutput("step_phase", 32'(phase), 32'd6);
        checkOutput("step_paused", 32'(paused), 32'd1);
        doFrame(ticks);
        checkOutput("step_once", 32'(phase), 32'd6);
        applyStimulus(0);
        doFrame(ticks);
        checkOutput("resume_paused", 32'(paused), 32'd0);
        checkOutput("resume_phase", 32'(phase), 32'd8);

        $display("[TB] step edge coinciding with frame tick");
        applyStimulus(0);
        doFrame(ticks);
        checkOutput("pause2_phase", 32'(phase), 32'd8);
        btnStep = 1'b1;
        @(negedge clk);
        vsync = 1'b0;
        @(negedge clk);
        checkOutput("coincident_tick", 32'(frameTick), 32'd1);
        @(negedge clk);
        btnStep = 1'b0;
        vsync   = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("coincident_not_yet", 32'(phase), 32'd8);
        doFrame(ticks);
        checkOutput("coincident_kept", 32'(phase), 32'd10);
        checkOutput("coincident_paused", 32'(paused), 32'd1);
        applyStimulus(0);
        doFrame(ticks);
        checkOutput("resume2_phase", 32'(phase), 32'd12);

        $display("[TB] pause and step together from run");
        btnPause = 1'b1;
        btnStep  = 1'b1;
        repeat (2) @(negedge clk);
        btnPause = 1'b0;
        btnStep  = 1'b0;
        repeat (4) @(negedge clk);
        doFrame(ticks);
        checkOutput("pause_step_paused", 32'(paused), 32'd1);
        checkOutput("pause_step_phase", 32'(phase), 32'd14);
        doFrame(ticks);
        checkOutput("pause_step_frozen", 32'(phase), 32'd14);
        applyStimulus(0);
        doFrame(ticks);
        checkOutput("resume3_phase", 32'(phase), 32'd16);

        $display("[TB] mode selection");
        repeat (4) applyStimulus(2);
        doFrame(ticks);
        checkOutput("mode_collapse", 32'(mode), 32'd1);
        applyStimulus(2);
        doFrame(ticks);
        checkOutput("mode_2", 32'(mode), 32'd2);
        applyStimulus(2);
        doFrame(ticks);
        checkOutput("mode_3", 32'(mode), 32'd3);
        applyStimulus(2);
        doFrame(ticks);
        checkOutput("mode_wrap", 32'(mode), 32'd0);
        applyStimulus(2);
        doFrame(ticks);
        checkOutput("mode_1_again", 32'(mode), 32'd1);
`endif

        $display("[TB] asynchronous reset mid-frame");
        vsync = 1'b0;
        @(negedge clk);
        checkOutput("pre_reset_tick", 32'(frameTick), 32'd1);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("async_tick", 32'(frameTick), 32'd0);
        checkOutput("async_phase", 32'(phase), 32'd0);
        checkOutput("async_mode", 32'(mode), 32'd0);
        checkOutput("async_paused", 32'(paused), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
